// File: rtl/floo_wormhole_rr_arbiter_if.sv
// ============================================================================
// Module      : floo_wormhole_rr_arbiter_if
// Description : Flit channel bundle for the wormhole round-robin arbiter.
//               Carries the NumInp competing input channels, the shared output
//               channel and the arbiter status (sel/locked).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface floo_wormhole_rr_arbiter_if #(
  parameter int unsigned NumInp    = 5,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;

  // Competing input channels
  logic [NumInp-1:0]                valid_i;
  logic [NumInp-1:0]                ready_o;
  logic [NumInp-1:0][DataWidth-1:0] data_i;
  logic [NumInp-1:0]                last_i;

  // Shared output channel
  logic                             valid_o;
  logic                             ready_i;
  logic [DataWidth-1:0]             data_o;
  logic                             last_o;

  // Status
  logic [IdxW-1:0]                  sel_o;
  logic                             locked_o;

  // Environment side: drives input flits and downstream ready
  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, sel_o, locked_o
  );

  // Arbiter side
  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, last_o, sel_o, locked_o
  );
endinterface

`default_nettype wire

// File: rtl/floo_wormhole_rr_arbiter.sv
// ============================================================================
// Module      : floo_wormhole_rr_arbiter
// Description : Per-output-port wormhole packet arbiter. Round-robin grant
//               among NumInp inputs, locked to the granted input until its
//               last flit is transferred. Combinational 0-cycle datapath.
//               Optional per-input completed-packet counters are enabled by
//               defining FLOO_WH_ARB_PKT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module floo_wormhole_rr_arbiter #(
  parameter int unsigned NumInp    = 5,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  wire logic                             clk_i,
  input  wire logic                             rst_ni,
  floo_wormhole_rr_arbiter_if.slave             bus,
  input  wire logic                             clr_cnt_i,
  output logic [NumInp-1:0][CntWidth-1:0]       pkt_cnt_o
);

  localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;

  // One extra bit so rr_ptr + offset never overflows before the wrap compare
  localparam logic [IdxW:0]   NUM_EXT  = (IdxW+1)'(NumInp);
  localparam logic [IdxW-1:0] LAST_IDX = IdxW'(NumInp - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state, state_nxt;
  logic [IdxW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IdxW-1:0]   lock_idx, lock_idx_nxt;

  logic              grant_found;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW:0]     cand;

  logic [IdxW-1:0]   sel;
  logic              out_valid;
  logic              out_last;
  logic [NumInp-1:0] in_ready;
  logic              handshake;

  // Successor index with wrap by compare, so non power-of-2 NumInp is exact
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IdxW'(1);
  endfunction

  // Round-robin scan: first valid input starting at rr_ptr, wrapping to 0
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    cand        = '0;
    for (int k = 0; k < NumInp; k++) begin
      cand = {1'b0, rr_ptr} + (IdxW+1)'(k);
      if (cand >= NUM_EXT) begin
        cand = cand - NUM_EXT;
      end
      if (!grant_found && bus.valid_i[cand[IdxW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Output mux: locked input wins, otherwise the fresh round-robin grant
  always_comb begin
    sel       = (state == LOCKED) ? lock_idx : grant_idx;
    out_valid = (state == LOCKED) ? bus.valid_i[lock_idx] : grant_found;
    out_last  = bus.last_i[sel];
    handshake = out_valid & bus.ready_i;
    in_ready      = '0;
    in_ready[sel] = bus.ready_i & out_valid;
  end

  assign bus.valid_o  = out_valid;
  assign bus.data_o   = bus.data_i[sel];
  assign bus.last_o   = out_last;
  assign bus.ready_o  = in_ready;
  assign bus.sel_o    = sel;
  assign bus.locked_o = (state == LOCKED);

  // FSM state and pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  // FSM next state: lock on any unfinished grant, release on last handshake
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    lock_idx_nxt = lock_idx;
    case (state)
      IDLE: begin
        if (grant_found) begin
          if (handshake && out_last) begin
            // single-flit packet: granted and released in one cycle
            rr_ptr_nxt = wrap_inc(grant_idx);
          end else begin
            // hold the grant so valid/data stay stable under backpressure
            state_nxt    = LOCKED;
            lock_idx_nxt = grant_idx;
          end
        end
      end
      LOCKED: begin
        if (handshake && out_last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = wrap_inc(lock_idx);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef FLOO_WH_ARB_PKT_CNT_EN
  localparam logic [CntWidth-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < NumInp; i++) begin : g_pkt_cnt
    logic [CntWidth-1:0] cnt;

    // Saturating completed-packet counter; clear beats a same-cycle increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt <= '0;
      end else if (clr_cnt_i) begin
        cnt <= '0;
      end else if (handshake && out_last && (sel == IdxW'(i)) && (cnt != CNT_MAX)) begin
        cnt <= cnt + CntWidth'(1);
      end
    end

    assign pkt_cnt_o[i] = cnt;
  end
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt_i;
  assign pkt_cnt_o      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_floo_wormhole_rr_arbiter.sv
// ============================================================================
// Module      : tb_floo_wormhole_rr_arbiter
// Description : Directed self-checking bench for floo_wormhole_rr_arbiter
//               (NumInp=5, DataWidth=64, CntWidth=4). Counter expectations
//               follow FLOO_WH_ARB_PKT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_floo_wormhole_rr_arbiter;
  localparam int NI = 5;
  localparam int DW = 64;
  localparam int CW = 4;
`ifdef FLOO_WH_ARB_PKT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  clr_cnt;
  logic [NI-1:0][CW-1:0] pkt_cnt;
  logic [NI-1:0][CW-1:0] ec;
  int                    total = 0;
  int                    bad   = 0;
  int                    seq [3] = '{0, 2, 4};

  floo_wormhole_rr_arbiter_if #(.NumInp(NI), .DataWidth(DW)) bus ();

  floo_wormhole_rr_arbiter #(.NumInp(NI), .DataWidth(DW), .CntWidth(CW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .clr_cnt_i (clr_cnt),
    .pkt_cnt_o (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pay(input int i, input int f);
    return 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(f);
  endfunction

  function automatic logic [63:0] cnt_exp(input logic [NI*CW-1:0] v);
    return CNT_EN ? 64'(v) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NI-1:0] v, input logic [NI-1:0] l, input logic r);
    bus.valid_i = v;
    bus.last_i  = l;
    bus.ready_i = r;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input int s,
                            input logic [NI-1:0] rdy, input logic lk, input logic [63:0] d);
    chk($sformatf("%s.valid", tag),  64'(bus.valid_o),  64'(v));
    chk($sformatf("%s.sel", tag),    64'(bus.sel_o),    64'(s));
    chk($sformatf("%s.ready", tag),  64'(bus.ready_o),  64'(rdy));
    chk($sformatf("%s.locked", tag), 64'(bus.locked_o), 64'(lk));
    if (v) chk($sformatf("%s.data", tag), bus.data_o, d);
  endtask

  initial begin
    rst_n       = 1'b0;
    clr_cnt     = 1'b0;
    bus.valid_i = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b0;
    for (int i = 0; i < NI; i++) bus.data_i[i] = pay(i, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state, nothing valid
    expect_out("reset", 1'b0, 0, 5'b00000, 1'b0, 64'd0);
    chk("reset.cnt", 64'(pkt_cnt), 64'd0);

    // Single-flit packets on 0, 2, 4: grant order 0,2,4,0,2,4
    for (int c = 0; c < 6; c++) begin
      drive(5'b10101, 5'b11111, 1'b1);
      expect_out($sformatf("rr_single%0d", c), 1'b1, seq[c % 3],
                 5'(1 << seq[c % 3]), 1'b0, pay(seq[c % 3], 0));
      tick();
    end
    drive(5'b00000, 5'b00000, 1'b0);
    ec = '0; ec[0] = 4'd2; ec[2] = 4'd2; ec[4] = 4'd2;
    chk("rr_single.cnt", 64'(pkt_cnt), cnt_exp(ec));

    // 4-flit packet on input 1 while input 3 waits
    for (int f = 0; f < 4; f++) begin
      bus.data_i[1] = pay(1, f);
      drive(5'b01010, (f == 3) ? 5'b01010 : 5'b01000, 1'b1);
      expect_out($sformatf("wh_flit%0d", f), 1'b1, 1, 5'b00010, (f != 0), pay(1, f));
      tick();
    end
    // rr_ptr is now 2: input 3 beats a fresh packet on input 1
    bus.data_i[1] = pay(1, 9);
    drive(5'b01010, 5'b01010, 1'b1);
    expect_out("wh_after", 1'b1, 3, 5'b01000, 1'b0, pay(3, 0));
    tick();
    drive(5'b00010, 5'b00010, 1'b1);
    expect_out("wh_next", 1'b1, 1, 5'b00010, 1'b0, pay(1, 9));
    tick();

    // Backpressure on input 4, then input 0 joins
    bus.data_i[4] = pay(4, 7);
    for (int c = 0; c < 3; c++) begin
      drive(5'b10000, 5'b10000, 1'b0);
      expect_out($sformatf("bp%0d", c), 1'b1, 4, 5'b00000, (c != 0), pay(4, 7));
      tick();
    end
    drive(5'b10001, 5'b10001, 1'b1);
    expect_out("bp_release", 1'b1, 4, 5'b10000, 1'b1, pay(4, 7));
    tick();
    drive(5'b10001, 5'b10001, 1'b1);
    expect_out("bp_wrap", 1'b1, 0, 5'b00001, 1'b0, pay(0, 0));
    tick();
    drive(5'b00000, 5'b00000, 1'b0);
    expect_out("idle_sel_rr", 1'b0, 1, 5'b00000, 1'b0, 64'd0);
    ec = '0; ec[0] = 4'd3; ec[1] = 4'd2; ec[2] = 4'd2; ec[3] = 4'd1; ec[4] = 4'd3;
    chk("mix.cnt", 64'(pkt_cnt), cnt_exp(ec));

    // 3-flit packet on input 2 with a bubble, reset at flit 2
    bus.data_i[2] = pay(2, 1);
    drive(5'b00100, 5'b00000, 1'b1);
    expect_out("lk_flit1", 1'b1, 2, 5'b00100, 1'b0, pay(2, 1));
    tick();
    drive(5'b00000, 5'b00000, 1'b1);
    expect_out("lk_bubble", 1'b0, 2, 5'b00000, 1'b1, 64'd0);
    tick();
    bus.data_i[2] = pay(2, 2);
    drive(5'b00100, 5'b00000, 1'b0);
    expect_out("lk_flit2", 1'b1, 2, 5'b00000, 1'b1, pay(2, 2));
    rst_n = 1'b0;
    #1;
    chk("rst_async.locked", 64'(bus.locked_o), 64'd0);
    chk("rst_async.cnt", 64'(pkt_cnt), 64'd0);
    rst_n = 1'b1;
    drive(5'b00101, 5'b00101, 1'b1);
    expect_out("rst_first", 1'b1, 0, 5'b00001, 1'b0, pay(0, 0));
    tick();
    drive(5'b00100, 5'b00100, 1'b1);
    expect_out("rst_second", 1'b1, 2, 5'b00100, 1'b0, pay(2, 2));
    tick();

    // 20 single-flit packets on input 1: counter saturates
    for (int n = 0; n < 20; n++) begin
      drive(5'b00010, 5'b00010, 1'b1);
      tick();
    end
    drive(5'b00000, 5'b00000, 1'b0);
    ec = '0; ec[0] = 4'd1; ec[1] = 4'd15; ec[2] = 4'd1;
    chk("sat.cnt", 64'(pkt_cnt), cnt_exp(ec));

    // Clear together with a last handshake: clear wins
    clr_cnt = 1'b1;
    drive(5'b00010, 5'b00010, 1'b1);
    expect_out("clr_hs", 1'b1, 1, 5'b00010, 1'b0, pay(1, 9));
    tick();
    clr_cnt = 1'b0;
    drive(5'b00000, 5'b00000, 1'b0);
    chk("clr.cnt", 64'(pkt_cnt), 64'd0);
    drive(5'b00010, 5'b00010, 1'b1);
    tick();
    drive(5'b00000, 5'b00000, 1'b0);
    ec = '0; ec[1] = 4'd1;
    chk("post_clr.cnt", 64'(pkt_cnt), cnt_exp(ec));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/floo_wormhole_rr_arbiter.md
Name: floo_wormhole_rr_arbiter

Overview:
- Per-output-port packet arbiter for the narrow/wide router datapath. Shares one output flit channel among NumInp input channels.
- Round-robin selection; locks onto the granted input until its last flit is transferred, so packets are never interleaved.
- Sits between the router input FIFOs and each output port; one instance per direction and per physical channel (req, rsp, wide).

Parameters:
- NumInp, 5, number of competing input channels (>=1); North..West plus Eject.
- DataWidth, 64, flit payload width in bits, last bit excluded.
- CntWidth, 16, width of per-input packet counters (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  NumInp  per-input flit valid
- ready_o  out  NumInp  per-input flit ready
- data_i  in  NumInp x DataWidth  per-input flit payload
- last_i  in  NumInp  per-input last-flit-of-packet marker
- valid_o  out  1  output flit valid
- ready_i  in  1  output flit ready (downstream)
- data_o  out  DataWidth  selected payload
- last_o  out  1  selected last marker
- sel_o  out  max(1,$clog2(NumInp))  index of currently selected input
- locked_o  out  1  arbiter is in LOCKED state
- clr_cnt_i  in  1  synchronous clear of packet counters
- pkt_cnt_o  out  NumInp x CntWidth  per-input completed-packet count

Behaviour:
- Datapath is combinational, 0-cycle latency: data_o/last_o = data_i/last_i[sel_o]; valid_o = valid_i[sel_o] when a grant exists; ready_o[sel_o] = ready_i; all other ready_o bits = 0.
- State: FSM {IDLE, LOCKED}, rr_ptr (index width as sel_o), lock_idx.
- Reset: state IDLE, rr_ptr = 0, lock_idx = 0, counters 0. With all valid_i = 0: valid_o = 0, ready_o = 0, sel_o = 0, locked_o = 0.
- IDLE:
  - Grant goes to the first asserted valid_i scanning rr_ptr, rr_ptr+1, ..., wrapping NumInp-1 -> 0. Wrap is by compare, not power-of-2 masking.
  - No valid: valid_o = 0 and sel_o = rr_ptr.
  - Handshake (valid_o && ready_i) with last_i[g] = 1: stay IDLE; rr_ptr <= (g == NumInp-1) ? 0 : g+1.
  - Any other cycle with valid_o = 1 (no handshake, or handshake of a non-last flit): go LOCKED, lock_idx <= g. This keeps valid_o/data_o stable under downstream backpressure.
- LOCKED:
  - sel_o = lock_idx; only that input is served.
  - Other inputs see ready_o = 0 regardless of their valid.
  - Handshake with last_i[lock_idx] = 1: go IDLE; rr_ptr <= lock_idx+1 (with wrap).
  - valid_i[lock_idx] dropping mid-packet (bubble): remain LOCKED, valid_o = 0.
- Upstream requirement: a valid flit is held stable until accepted. The arbiter never retracts valid_o once asserted.
- Single-flit packet (last on first flit, ready_i = 1): granted and released in the same cycle, never enters LOCKED.
- NumInp = 1: rr_ptr and sel_o constant 0; FSM still tracks lock for locked_o.
- Reset asserted mid-packet: immediate return to IDLE and rr_ptr = 0; partial packet ownership is discarded.
- locked_o = (state == LOCKED).

Optional Feature:
- Macro: FLOO_WH_ARB_PKT_CNT_EN.
- Defined:
  - pkt_cnt_o[i] increments by 1 on each last-flit handshake from input i.
  - Saturates at 2^CntWidth-1.
  - clr_cnt_i = 1 zeroes all counters next edge and takes priority over a same-cycle increment.
- Undefined: no counter flops; pkt_cnt_o tied to 0; clr_cnt_i ignored.

Test Plan:
- Reset then all valid_i = 0 -> valid_o = 0, ready_o = 0, sel_o = 0, locked_o = 0.
- NumInp = 5, inputs 0, 2, 4 each send single-flit packets continuously with ready_i = 1 -> grant order 0, 2, 4, 0, 2, 4; one flit per cycle; locked_o stays 0.
- Input 1 sends a 4-flit packet while input 3 is valid from the first cycle -> sel_o = 1 for 4 handshakes, ready_o[3] = 0 throughout; input 3 granted the cycle after last; rr_ptr = 2 afterwards.
- Input 4 valid with ready_i held 0 for 3 cycles, then input 0 asserts valid -> sel_o stays 4 and data_o stable; input 4 completes when ready_i = 1; next grant is 0 (wrap).
- Reset pulse while LOCKED on input 2 at flit 2 of 3 -> after release state is IDLE, rr_ptr = 0; input 0 is granted first if valid.
- FLOO_WH_ARB_PKT_CNT_EN, CntWidth = 4: input 1 sends 20 single-flit packets -> pkt_cnt_o[1] = 15 (saturated). Pulse clr_cnt_i together with a last handshake -> counter = 0.
